// File: rtl/jtag_pkg.sv
// jtag_pkg: shared types and instruction codes for the multi-register JTAG TAP.
// The BYPASS code is all-ones of the IR width and is derived in the top.
package jtag_pkg;

  // The 16 IEEE 1149.1 controller states.
  typedef enum logic [3:0] {
    ST_TLR      = 4'h0,
    ST_RTI      = 4'h1,
    ST_SEL_DR   = 4'h2,
    ST_CAP_DR   = 4'h3,
    ST_SHIFT_DR = 4'h4,
    ST_EXIT1_DR = 4'h5,
    ST_PAUSE_DR = 4'h6,
    ST_EXIT2_DR = 4'h7,
    ST_UPD_DR   = 4'h8,
    ST_SEL_IR   = 4'h9,
    ST_CAP_IR   = 4'hA,
    ST_SHIFT_IR = 4'hB,
    ST_EXIT1_IR = 4'hC,
    ST_PAUSE_IR = 4'hD,
    ST_EXIT2_IR = 4'hE,
    ST_UPD_IR   = 4'hF
  } tap_state_t;

  // Which data register sits between tdi and tdo.
  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_BSR    = 2'd2,
    DR_USER   = 2'd3
  } dr_sel_t;

  localparam int INS_EXTEST         = 0;
  localparam int INS_IDCODE         = 1;
  localparam int INS_SAMPLE_PRELOAD = 2;
  localparam int INS_CLAMP          = 3;
  localparam int INS_USER_BASE      = 8;

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: TAP controller state register, next-state logic and
// decoded capture/shift/update strobes for the IR and DR columns.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state,
  output tap_state_t state_next,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr
);

  tap_state_t state_r;
  tap_state_t state_next_s;

  // State register; trst parks the controller in Test-Logic-Reset.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) state_r <= ST_TLR;
    else      state_r <= state_next_s;
  end

  // Standard tms-driven transitions.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_TLR:      state_next_s = tms ? ST_TLR      : ST_RTI;
      ST_RTI:      state_next_s = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_next_s = tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_next_s = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: state_next_s = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: state_next_s = tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_next_s = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: state_next_s = tms ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   state_next_s = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_next_s = tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_next_s = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: state_next_s = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: state_next_s = tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_next_s = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: state_next_s = tms ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   state_next_s = tms ? ST_SEL_DR   : ST_RTI;
      default:     state_next_s = ST_TLR;
    endcase
  end

  assign state      = state_r;
  assign state_next = state_next_s;
  assign capture_ir = (state_r == ST_CAP_IR);
  assign shift_ir   = (state_r == ST_SHIFT_IR);
  assign update_ir  = (state_r == ST_UPD_IR);
  assign capture_dr = (state_r == ST_CAP_DR);
  assign shift_dr   = (state_r == ST_SHIFT_DR);
  assign update_dr  = (state_r == ST_UPD_DR);

endmodule

// File: rtl/jtag_tap_multi.sv
// jtag_tap_multi: IEEE 1149.1 TAP with configurable IR, BYPASS, IDCODE,
// external BSR control and NUM_USER user data registers.
// Optional feature: define JTAG_CLAMP_EN to make IR code 3 a CLAMP
// instruction (BYPASS data path, bsr_extest held high).
// Constraints: IR_WIDTH >= 4, USER_WIDTH >= 2, IDCODE_VAL[0] = 1,
// NUM_USER <= 2**IR_WIDTH - 9.
module jtag_tap_multi
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int          NUM_USER   = 2,
  parameter int          USER_WIDTH = 8
) (
  input  logic                           tck,
  input  logic                           trst,
  input  logic                           tms,
  input  logic                           tdi,
  output logic                           tdo,
  output logic                           tdo_en,
  output logic                           bsr_tdi,
  input  logic                           bsr_tdo,
  output logic                           bsr_capture,
  output logic                           bsr_shift,
  output logic                           bsr_update,
  output logic                           bsr_extest,
  input  logic [NUM_USER*USER_WIDTH-1:0] user_capture_data,
  output logic [NUM_USER*USER_WIDTH-1:0] user_update_data,
  output logic [NUM_USER-1:0]            user_update_valid,
  output logic                           tlr
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(INS_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = '1;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, 2'b01};

  tap_state_t state_s, state_next_s;
  logic capture_ir_s, shift_ir_s, update_ir_s;
  logic capture_dr_s, shift_dr_s, update_dr_s;

  logic [IR_WIDTH-1:0]            ir_r, ir_shift_r;
  logic                           bypass_r;
  logic [31:0]                    idcode_r;
  logic [USER_WIDTH-1:0]          user_shift_r;
  logic [NUM_USER*USER_WIDTH-1:0] user_data_r;
  logic [NUM_USER-1:0]            user_valid_r;

  dr_sel_t                        dr_sel_s;
  logic [NUM_USER-1:0]            user_hit_s;
  logic [USER_WIDTH-1:0]          user_cap_s;
  logic                           bsr_sel_s;
  logic                           extest_s;
  logic                           tdo_s;

  jtag_tap_fsm u_fsm (
    .tck        (tck),
    .trst       (trst),
    .tms        (tms),
    .state      (state_s),
    .state_next (state_next_s),
    .capture_ir (capture_ir_s),
    .shift_ir   (shift_ir_s),
    .update_ir  (update_ir_s),
    .capture_dr (capture_dr_s),
    .shift_dr   (shift_dr_s),
    .update_dr  (update_dr_s)
  );

  // Instruction decode: pick the data path and the BSR pin-drive mode.
  always_comb begin
    user_hit_s = '0;
    user_cap_s = '0;
    for (int k = 0; k < NUM_USER; k++) begin
      user_hit_s[k] = (ir_r == IR_WIDTH'(INS_USER_BASE + k));
      user_cap_s    = user_cap_s |
                      ({USER_WIDTH{user_hit_s[k]}} & user_capture_data[k*USER_WIDTH +: USER_WIDTH]);
    end
    dr_sel_s  = DR_BYPASS;
    bsr_sel_s = 1'b0;
    extest_s  = 1'b0;
    if (ir_r == IR_WIDTH'(INS_EXTEST)) begin
      dr_sel_s  = DR_BSR;
      bsr_sel_s = 1'b1;
      extest_s  = 1'b1;
    end else if (ir_r == IR_IDCODE) begin
      dr_sel_s = DR_IDCODE;
    end else if (ir_r == IR_WIDTH'(INS_SAMPLE_PRELOAD)) begin
      dr_sel_s  = DR_BSR;
      bsr_sel_s = 1'b1;
    end else if (|user_hit_s) begin
      dr_sel_s = DR_USER;
    end else begin
      // CLAMP and every unassigned code (including all-ones) use BYPASS.
      dr_sel_s = DR_BYPASS;
`ifdef JTAG_CLAMP_EN
      extest_s = (ir_r == IR_WIDTH'(INS_CLAMP));
`else
      extest_s = 1'b0;
`endif
    end
  end

  // Instruction shift register and active IR; entering TLR restores IDCODE.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_r       <= IR_IDCODE;
      ir_shift_r <= '0;
    end else begin
      if (state_next_s == ST_TLR) ir_r <= IR_IDCODE;
      else if (update_ir_s)       ir_r <= ir_shift_r;
      if (capture_ir_s)           ir_shift_r <= IR_CAPTURE;
      else if (shift_ir_s)        ir_shift_r <= {tdi, ir_shift_r[IR_WIDTH-1:1]};
    end
  end

  // Internal data registers capture and shift together; only the selected one reaches tdo.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      bypass_r     <= 1'b0;
      idcode_r     <= '0;
      user_shift_r <= '0;
    end else if (capture_dr_s) begin
      bypass_r     <= 1'b0;
      idcode_r     <= IDCODE_VAL;
      user_shift_r <= user_cap_s;
    end else if (shift_dr_s) begin
      bypass_r     <= tdi;
      idcode_r     <= {tdi, idcode_r[31:1]};
      user_shift_r <= {tdi, user_shift_r[USER_WIDTH-1:1]};
    end
  end

  // User update registers and their one-cycle valid pulse after Update-DR.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      user_data_r  <= '0;
      user_valid_r <= '0;
    end else begin
      user_valid_r <= (update_dr_s && (dr_sel_s == DR_USER)) ? user_hit_s : '0;
      for (int k = 0; k < NUM_USER; k++) begin
        if (update_dr_s && user_hit_s[k]) user_data_r[k*USER_WIDTH +: USER_WIDTH] <= user_shift_r;
      end
    end
  end

  // tdo mux: IR LSB in Shift-IR, selected DR LSB in Shift-DR, otherwise 0.
  always_comb begin
    tdo_s = 1'b0;
    if (shift_ir_s) begin
      tdo_s = ir_shift_r[0];
    end else if (shift_dr_s) begin
      case (dr_sel_s)
        DR_BYPASS: tdo_s = bypass_r;
        DR_IDCODE: tdo_s = idcode_r[0];
        DR_BSR:    tdo_s = bsr_tdo;
        DR_USER:   tdo_s = user_shift_r[0];
        default:   tdo_s = 1'b0;
      endcase
    end else begin
      tdo_s = 1'b0;
    end
  end

  assign tdo               = tdo_s;
  assign tdo_en            = shift_ir_s | shift_dr_s;
  assign bsr_tdi           = tdi;
  assign bsr_capture       = capture_dr_s & bsr_sel_s;
  assign bsr_shift         = shift_dr_s & bsr_sel_s;
  assign bsr_update        = update_dr_s & bsr_sel_s;
  assign bsr_extest        = extest_s;
  assign user_update_data  = user_data_r;
  assign user_update_valid = user_valid_r;
  assign tlr               = (state_s == ST_TLR);

endmodule
